// File: rtl/mbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbox_pkg
// Description : Shared constants for the EBOX-to-MBOX request controller:
//               controller state encoding, error cause codes, VMA field range.
// Revision    : 1.0  initial release
// ============================================================================
package mbox_pkg;

    // VMA field uses PDP-10 bit numbering: bits 13..35 of the address word
    localparam int c_VMA_FIRST = 13;
    localparam int c_VMA_W     = 23;
    localparam int c_VMA_LAST  = c_VMA_FIRST + c_VMA_W - 1;

    // Controller state encoding
    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_REQ   = 3'd1;
    localparam state_t c_ST_WAIT  = 3'd2;
    localparam state_t c_ST_RETRY = 3'd3;
    localparam state_t c_ST_ERROR = 3'd4;

    // Error cause codes reported on errCode
    localparam logic [2:0] c_ERR_NONE   = 3'd0;
    localparam logic [2:0] c_ERR_ADRPAR = 3'd1;
    localparam logic [2:0] c_ERR_MBPAR  = 3'd2;
    localparam logic [2:0] c_ERR_CDIR   = 3'd3;
    localparam logic [2:0] c_ERR_NXM    = 3'd4;
    localparam logic [2:0] c_ERR_ILL    = 3'd5;
    localparam logic [2:0] c_ERR_TMO    = 3'd6;
    localparam logic [2:0] c_ERR_RETRY  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/mbox_err_latch.sv
`default_nettype none
// ============================================================================
// Module      : mbox_err_latch
// Description : Priority-encodes the MBOX error flags and holds the first
//               error cause (MBOX or controller-detected) until cleared.
// Revision    : 1.0  initial release
// ============================================================================
module mbox_err_latch
    import mbox_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sample,     // MBOX flags are meaningful this cycle
    input  logic       i_adr_par,
    input  logic       i_mb_par,
    input  logic       i_cdir_par,
    input  logic       i_nxm,
    input  logic       i_sbus,
    input  logic       i_fsm_set,    // controller-detected error this cycle
    input  logic [2:0] i_fsm_code,
    input  logic       i_clear,
    output logic       o_hw_err,     // sampled MBOX error present (combinational)
    output logic       o_any_err,
    output logic [2:0] o_err_code
);

    logic [2:0] w_hw_code;
    logic       r_any_err;
    logic [2:0] r_err_code;

    // Highest-priority cause among the raw MBOX error flags
    always_comb begin
        w_hw_code = c_ERR_NONE;
        if (i_adr_par)             w_hw_code = c_ERR_ADRPAR;
        else if (i_mb_par)         w_hw_code = c_ERR_MBPAR;
        else if (i_cdir_par)       w_hw_code = c_ERR_CDIR;
        else if (i_nxm || i_sbus)  w_hw_code = c_ERR_NXM;
    end

    assign o_hw_err = i_sample && (i_adr_par || i_mb_par || i_cdir_par || i_nxm || i_sbus);

    // Sticky cause register: the first cause is frozen until an explicit clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_err  <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else if (i_clear) begin
            r_any_err  <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else if (!r_any_err) begin
            if (o_hw_err) begin
                r_any_err  <= 1'b1;
                r_err_code <= w_hw_code;
            end else if (i_fsm_set) begin
                r_any_err  <= 1'b1;
                r_err_code <= i_fsm_code;
            end
        end
    end

    assign o_any_err  = r_any_err;
    assign o_err_code = r_err_code;

endmodule
`default_nettype wire

// File: rtl/mbox_req_ctl.sv
`default_nettype none
// ============================================================================
// Module      : mbox_req_ctl
// Description : Latches EBOX memory references, presents them to the MBOX,
//               runs the T0 / retry / response handshake, stalls the EBOX
//               while a reference is outstanding and returns read data.
// Revision    : 1.0  initial release
// ============================================================================
module mbox_req_ctl
    import mbox_pkg::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 7,
    parameter int RETRY_GAP = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         eboxReq,
    input  logic [c_VMA_FIRST:c_VMA_LAST] eboxVMA,
    input  logic                         eboxRead,
    input  logic                         eboxWrite,
    input  logic                         eboxPSE,
    input  logic [0:35]                  eboxWData,
    input  logic                         cshEBOXT0,
    input  logic                         cshEBOXRetry,
    input  logic                         mboxRespIn,
    input  logic [0:35]                  cacheData,
    input  logic                         cshAdrParErr,
    input  logic                         mbParErr,
    input  logic                         sbusErr,
    input  logic                         nxmErr,
    input  logic                         mboxCDirParErr,
    input  logic                         errClear,
    output logic                         mboxReq,
    output logic [c_VMA_FIRST:c_VMA_LAST] mboxVMA,
    output logic                         mboxRead,
    output logic                         mboxWrite,
    output logic                         mboxPSE,
    output logic [0:35]                  mboxWData,
    output logic                         eboxHold,
    output logic [0:35]                  eboxRdData,
    output logic                         eboxRdValid,
    output logic                         anyEboxError,
    output logic [2:0]                   errCode,
    output logic [2:0]                   retryCount
);

    localparam int c_TMR_W = $clog2(TIMEOUT);
    localparam int c_GAP_W = $clog2(RETRY_GAP + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST    = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST    = c_GAP_W'(RETRY_GAP - 1);
    localparam logic [3:0]         c_RETRY_LIMIT = 4'(MAX_RETRY);

    state_t                          r_state;
    state_t                          w_state_nx;
    logic [c_TMR_W-1:0]              r_timer;
    logic [c_GAP_W-1:0]              r_gap;
    logic [2:0]                      r_retry_cnt;
    logic                            r_retry_ovf;
    logic [3:0]                      w_retry_inc;
    logic [c_VMA_FIRST:c_VMA_LAST]   r_vma;
    logic                            r_read;
    logic                            r_write;
    logic                            r_pse;
    logic [0:35]                     r_wdata;
    logic [0:35]                     r_rd_data;
    logic                            r_rd_valid;

    logic       w_accept;
    logic       w_timer_clr;
    logic       w_retry_take;
    logic       w_resp_done;
    logic       w_fsm_err_set;
    logic [2:0] w_fsm_err_code;
    logic       w_sample;
    logic       w_clear;
    logic       w_hw_err;
    logic       w_any_err;
    logic [2:0] w_err_code;

    assign w_sample    = (r_state == c_ST_REQ) || (r_state == c_ST_WAIT);
    assign w_clear     = (r_state == c_ST_ERROR) && errClear;
    // One wider so exhaustion is visible even though retryCount saturates
    assign w_retry_inc = {1'b0, r_retry_cnt} + 4'd1;

    mbox_err_latch u_err_latch (
        .clk        (clk),
        .rst        (reset),
        .i_sample   (w_sample),
        .i_adr_par  (cshAdrParErr),
        .i_mb_par   (mbParErr),
        .i_cdir_par (mboxCDirParErr),
        .i_nxm      (nxmErr),
        .i_sbus     (sbusErr),
        .i_fsm_set  (w_fsm_err_set),
        .i_fsm_code (w_fsm_err_code),
        .i_clear    (w_clear),
        .o_hw_err   (w_hw_err),
        .o_any_err  (w_any_err),
        .o_err_code (w_err_code)
    );

    // Next-state and handshake decode; MBOX errors outrank responses and retries
    always_comb begin
        w_state_nx     = r_state;
        w_accept       = 1'b0;
        w_timer_clr    = 1'b0;
        w_retry_take   = 1'b0;
        w_resp_done    = 1'b0;
        w_fsm_err_set  = 1'b0;
        w_fsm_err_code = c_ERR_NONE;
        case (r_state)
            c_ST_IDLE: begin
                if (eboxReq && (eboxRead ^ eboxWrite)) begin
                    w_accept   = 1'b1;
                    w_state_nx = c_ST_REQ;
                end else if (eboxReq && eboxRead && eboxWrite) begin
                    w_fsm_err_set  = 1'b1;
                    w_fsm_err_code = c_ERR_ILL;
                    w_state_nx     = c_ST_ERROR;
                end
            end
            c_ST_REQ: begin
                if (w_hw_err) begin
                    w_state_nx = c_ST_ERROR;
                end else if (cshEBOXRetry) begin
                    w_retry_take = 1'b1;
                    w_state_nx   = c_ST_RETRY;
                end else if (cshEBOXT0) begin
                    w_timer_clr = 1'b1;
                    w_state_nx  = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (w_hw_err) begin
                    w_state_nx = c_ST_ERROR;
                end else if (mboxRespIn) begin
                    w_resp_done = 1'b1;
                    w_state_nx  = c_ST_IDLE;
                end else if (cshEBOXRetry) begin
                    w_retry_take = 1'b1;
                    w_state_nx   = c_ST_RETRY;
                end else if (r_timer == c_TMR_LAST) begin
                    w_fsm_err_set  = 1'b1;
                    w_fsm_err_code = c_ERR_TMO;
                    w_state_nx     = c_ST_ERROR;
                end
            end
            c_ST_RETRY: begin
                if (r_retry_ovf) begin
                    w_fsm_err_set  = 1'b1;
                    w_fsm_err_code = c_ERR_RETRY;
                    w_state_nx     = c_ST_ERROR;
                end else if (r_gap == c_GAP_LAST) begin
                    w_state_nx = c_ST_REQ;
                end
            end
            c_ST_ERROR: begin
                if (errClear) w_state_nx = c_ST_IDLE;
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // Response timer: restarts on accept and on T0, runs only while waiting
    always_ff @(posedge clk) begin
        if (reset)                         r_timer <= '0;
        else if (w_accept || w_timer_clr)  r_timer <= '0;
        else if (r_state == c_ST_WAIT)     r_timer <= r_timer + 1'b1;
    end

    // Retry bookkeeping: saturating count, exhaustion flag and re-present gap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry_cnt <= 3'd0;
            r_retry_ovf <= 1'b0;
            r_gap       <= '0;
        end else begin
            if (w_accept) begin
                r_retry_cnt <= 3'd0;
                r_retry_ovf <= 1'b0;
            end else if (w_retry_take) begin
                if (r_retry_cnt != 3'd7) r_retry_cnt <= r_retry_cnt + 1'b1;
                r_retry_ovf <= (w_retry_inc > c_RETRY_LIMIT);
            end
            if (w_retry_take)                r_gap <= '0;
            else if (r_state == c_ST_RETRY)  r_gap <= r_gap + 1'b1;
        end
    end

    // Reference latch: captured once per accepted reference, constant afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vma   <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_pse   <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_vma   <= eboxVMA;
            r_read  <= eboxRead;
            r_write <= eboxWrite;
            r_pse   <= eboxPSE;
            r_wdata <= eboxWData;
        end
    end

    // Read return: capture cache data and pulse valid for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_resp_done && r_read;
            if (w_resp_done && r_read) r_rd_data <= cacheData;
        end
    end

    assign mboxReq      = (r_state == c_ST_REQ);
    assign eboxHold     = (r_state == c_ST_REQ) || (r_state == c_ST_WAIT) ||
                          (r_state == c_ST_RETRY);
    assign mboxVMA      = r_vma;
    assign mboxRead     = r_read;
    assign mboxWrite    = r_write;
    assign mboxPSE      = r_pse;
    assign mboxWData    = r_wdata;
    assign eboxRdData   = r_rd_data;
    assign eboxRdValid  = r_rd_valid;
    assign anyEboxError = w_any_err;
    assign errCode      = w_err_code;
    assign retryCount   = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mbox_req_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbox_req_ctl
// Description : Self-checking bench for mbox_req_ctl: decode/error table,
//               transaction timelines from a latency model, random traffic,
//               retry exhaustion, timeout and mid-reference reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mbox_req_ctl;

    localparam int TIMEOUT   = 64;
    localparam int MAX_RETRY = 7;
    localparam int RETRY_GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        eboxReq, eboxRead, eboxWrite, eboxPSE;
    logic [13:35] eboxVMA;
    logic [0:35] eboxWData, cacheData;
    logic        cshEBOXT0, cshEBOXRetry, mboxRespIn;
    logic        cshAdrParErr, mbParErr, sbusErr, nxmErr, mboxCDirParErr, errClear;
    logic        mboxReq, mboxRead, mboxWrite, mboxPSE;
    logic [13:35] mboxVMA;
    logic [0:35] mboxWData, eboxRdData;
    logic        eboxHold, eboxRdValid, anyEboxError;
    logic [2:0]  errCode, retryCount;

    mbox_req_ctl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)) dut (
        .clk(clk), .reset(reset), .eboxReq(eboxReq), .eboxVMA(eboxVMA),
        .eboxRead(eboxRead), .eboxWrite(eboxWrite), .eboxPSE(eboxPSE),
        .eboxWData(eboxWData), .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry),
        .mboxRespIn(mboxRespIn), .cacheData(cacheData), .cshAdrParErr(cshAdrParErr),
        .mbParErr(mbParErr), .sbusErr(sbusErr), .nxmErr(nxmErr),
        .mboxCDirParErr(mboxCDirParErr), .errClear(errClear), .mboxReq(mboxReq),
        .mboxVMA(mboxVMA), .mboxRead(mboxRead), .mboxWrite(mboxWrite),
        .mboxPSE(mboxPSE), .mboxWData(mboxWData), .eboxHold(eboxHold),
        .eboxRdData(eboxRdData), .eboxRdValid(eboxRdValid),
        .anyEboxError(anyEboxError), .errCode(errCode), .retryCount(retryCount)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        eboxReq = 0; eboxRead = 0; eboxWrite = 0; eboxPSE = 0;
        eboxVMA = '0; eboxWData = '0; cacheData = '0;
        cshEBOXT0 = 0; cshEBOXRetry = 0; mboxRespIn = 0;
        cshAdrParErr = 0; mbParErr = 0; sbusErr = 0; nxmErr = 0;
        mboxCDirParErr = 0; errClear = 0;
    endtask

    // ---------------- transaction-level latency model ----------------------
    // A reference is described by, per attempt a, the REQ cycle carrying T0
    // (ks[a]) and the WAIT cycle carrying retry or response (js[a]).
    typedef struct {
        logic       req, t0, rty, resp;
        logic [3:0] exp;      // {mboxReq, eboxHold, eboxRdValid, anyEboxError}
        logic       req_cyc;
    } step_t;

    int ks[8];
    int js[8];

    function automatic step_t mk(logic req, logic t0, logic rty, logic resp,
                                 logic [3:0] exp, logic rc);
        step_t s;
        s.req = req; s.t0 = t0; s.rty = rty; s.resp = resp; s.exp = exp; s.req_cyc = rc;
        return s;
    endfunction

    task automatic run_txn(input string tag, input logic rd, input logic [13:35] vma,
                           input logic [0:35] wdata, input logic [0:35] rdata,
                           input logic pse, input int nr);
        step_t q[$];
        q.push_back(mk(1, 0, 0, 0, 4'b0000, 0));
        for (int a = 0; a <= nr; a++) begin
            for (int i = 1; i <= ks[a]; i++)
                q.push_back(mk(0, i == ks[a], 0, 0, 4'b1100, 1));
            for (int i = 1; i <= js[a]; i++)
                q.push_back(mk(0, 0, (i == js[a]) && (a < nr), (i == js[a]) && (a == nr),
                               4'b0100, 0));
            if (a < nr)
                for (int g = 0; g < RETRY_GAP; g++) q.push_back(mk(0, 0, 0, 0, 4'b0100, 0));
        end
        q.push_back(mk(0, 0, 0, 0, {2'b00, rd, 1'b0}, 0));
        foreach (q[c]) begin
            chk({tag, "_ctl"}, {mboxReq, eboxHold, eboxRdValid, anyEboxError}, q[c].exp);
            if (q[c].req_cyc)
                chk({tag, "_latched"}, {mboxVMA, mboxRead, mboxWrite, mboxPSE, mboxWData},
                    {vma, rd, ~rd, pse, wdata});
            eboxReq      = q[c].req;
            eboxRead     = q[c].req ? rd : 1'($urandom_range(0, 1));
            eboxWrite    = q[c].req ? ~rd : 1'b0;
            eboxVMA      = q[c].req ? vma : 23'($urandom);
            eboxWData    = q[c].req ? wdata : 36'({$urandom, $urandom});
            eboxPSE      = q[c].req ? pse : ~pse;
            cshEBOXT0    = q[c].t0;
            cshEBOXRetry = q[c].rty;
            mboxRespIn   = q[c].resp;
            cacheData    = q[c].resp ? rdata : 36'({$urandom, $urandom});
            step();
        end
        clear_inputs();
        if (rd) chk({tag, "_rddata"}, eboxRdData, rdata);
        chk({tag, "_retrycount"}, retryCount, 3'(nr));
    endtask

    // ---------------- decode / error-priority table ------------------------
    typedef struct {
        logic       rd, wr;
        logic [4:0] flags;    // {adrPar, mbPar, cdirPar, nxm, sbus} during WAIT
        logic       resp;
        logic [2:0] code;
        logic       rdv;
        logic       acc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n;
        logic [0:35] d;
        tbl[0] = '{1, 0, 5'b00000, 1, 3'd0, 1, 1};
        tbl[1] = '{0, 1, 5'b00000, 1, 3'd0, 0, 1};
        tbl[2] = '{1, 0, 5'b01010, 1, 3'd2, 0, 1};
        tbl[3] = '{1, 0, 5'b11111, 1, 3'd1, 0, 1};
        tbl[4] = '{1, 0, 5'b00110, 1, 3'd3, 0, 1};
        tbl[5] = '{0, 1, 5'b00010, 1, 3'd4, 0, 1};
        tbl[6] = '{1, 0, 5'b00001, 1, 3'd4, 0, 1};
        tbl[7] = '{1, 1, 5'b00000, 0, 3'd5, 0, 0};
        tbl[8] = '{0, 0, 5'b00000, 0, 3'd0, 0, 0};
        tbl[9] = '{1, 0, 5'b00101, 0, 3'd3, 0, 1};

        clear_inputs();
        reset = 1;
        repeat (3) step();
        chk("reset_ctl", {mboxReq, mboxVMA, mboxRead, mboxWrite, mboxPSE, eboxHold,
                          eboxRdValid, anyEboxError, errCode, retryCount}, '0);
        chk("reset_data", {mboxWData, eboxRdData}, '0);
        reset = 0;
        step();

        foreach (tbl[i]) begin
            eboxReq = 1; eboxRead = tbl[i].rd; eboxWrite = tbl[i].wr;
            eboxVMA = 23'($urandom);
            step();
            clear_inputs();
            chk($sformatf("tbl%0d_accept", i), mboxReq, tbl[i].acc);
            if (tbl[i].acc) begin
                cshEBOXT0 = 1;
                step();
                cshEBOXT0 = 0;
                {cshAdrParErr, mbParErr, mboxCDirParErr, nxmErr, sbusErr} = tbl[i].flags;
                mboxRespIn = tbl[i].resp;
                cacheData  = 36'({$urandom, $urandom});
                step();
                clear_inputs();
            end
            chk($sformatf("tbl%0d_rdvalid", i), eboxRdValid, tbl[i].rdv);
            chk($sformatf("tbl%0d_code", i), {anyEboxError, errCode, eboxHold},
                {tbl[i].code != 3'd0, tbl[i].code, 1'b0});
            if (tbl[i].code != 3'd0) begin
                sbusErr = 1;
                step();
                step();
                sbusErr = 0;
                chk($sformatf("tbl%0d_sticky", i), {anyEboxError, errCode}, {1'b1, tbl[i].code});
                errClear = 1;
                step();
                errClear = 0;
                chk($sformatf("tbl%0d_clear", i), {anyEboxError, errCode, eboxHold}, '0);
            end
        end

        // Best-case read: rdValid exactly 3 cycles after eboxReq
        ks[0] = 1; js[0] = 1;
        run_txn("read_best", 1'b1, 23'o1234567, 36'o0, 36'o123456701234, 1'b0, 0);

        // Write held several REQ cycles; latched data must stay put
        ks[0] = 3; js[0] = 2;
        run_txn("write", 1'b0, 23'o7654321, 36'o777777777777, 36'o0, 1'b1, 0);

        // Two retries, each followed by the re-present gap
        for (int a = 0; a < 3; a++) begin ks[a] = 1; js[a] = 1; end
        run_txn("retry2", 1'b1, 23'o0000777, 36'o0, 36'o555555555555, 1'b0, 2);

        // Random references against the latency model
        for (int t = 0; t < 20; t++) begin
            int nr;
            nr = $urandom_range(0, 3);
            for (int a = 0; a <= nr; a++) begin
                ks[a] = $urandom_range(1, 3);
                js[a] = $urandom_range(1, 4);
            end
            run_txn($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 23'($urandom),
                    36'({$urandom, $urandom}), 36'({$urandom, $urandom}),
                    1'($urandom_range(0, 1)), nr);
        end

        // Eight consecutive retries exhaust the budget
        eboxReq = 1; eboxRead = 1; eboxVMA = 23'o1111111;
        step();
        clear_inputs();
        for (int r = 1; r <= 8; r++) begin
            n = 0;
            while (mboxReq !== 1'b1 && n < 10) begin step(); n++; end
            chk($sformatf("rty8_present%0d", r), mboxReq, 1'b1);
            cshEBOXT0 = 1;
            step();
            cshEBOXT0 = 0;
            cshEBOXRetry = 1;
            step();
            cshEBOXRetry = 0;
            if (r == 7) chk("rty8_count7", {retryCount, anyEboxError}, {3'd7, 1'b0});
        end
        n = 0;
        while (anyEboxError !== 1'b1 && n < 10) begin step(); n++; end
        chk("rty8_error", {anyEboxError, errCode, eboxHold, mboxReq, eboxRdValid},
            {1'b1, 3'd7, 3'b000});
        errClear = 1;
        step();
        errClear = 0;
        chk("rty8_clear", {anyEboxError, errCode, eboxHold}, '0);

        // Timeout: 64 WAIT cycles without a response
        eboxReq = 1; eboxRead = 1; eboxVMA = 23'o2222222;
        step();
        clear_inputs();
        cshEBOXT0 = 1;
        step();
        cshEBOXT0 = 0;
        repeat (TIMEOUT - 1) step();
        chk("tmo_last_wait", {anyEboxError, eboxHold}, {1'b0, 1'b1});
        step();
        chk("tmo_error", {anyEboxError, errCode, eboxHold, mboxReq}, {1'b1, 3'd6, 2'b00});
        errClear = 1;
        step();
        errClear = 0;
        chk("tmo_clear", {anyEboxError, errCode, eboxHold, mboxReq}, '0);

        // Reset during WAIT, coinciding with a response
        eboxReq = 1; eboxRead = 1; eboxVMA = 23'o3333333; eboxWData = 36'o123;
        step();
        clear_inputs();
        cshEBOXT0 = 1;
        step();
        cshEBOXT0 = 0;
        reset = 1; mboxRespIn = 1; cacheData = 36'o707070707070;
        step();
        reset = 0; mboxRespIn = 0;
        chk("rst_wait_ctl", {mboxReq, mboxVMA, mboxRead, mboxWrite, mboxPSE, eboxHold,
                             eboxRdValid, anyEboxError, errCode, retryCount}, '0);
        chk("rst_wait_data", {mboxWData, eboxRdData}, '0);
        step();
        chk("rst_wait_no_rdv", {eboxRdValid, eboxHold}, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
